cache_tag_lookup: RTL and testbench
===================================

Name: cache_tag_lookup

Overview:
- 4-way set-associative tag store and compare stage; sits directly upstream of encoder4to2.
- Produces the registered one-hot way-hit vector that encoder4to2 turns into a 2-bit way index.
- Also holds per-set valid bits and tree pseudo-LRU state, and selects the victim way on fills.

Parameters:
- TAG_W, 8, tag width in bits.
- SETS, 8, number of sets; power of two, 2 or more.
- IDX_W, 3, set index width; must equal log2(SETS).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  lookup request strobe.
- req_index  input  IDX_W  lookup set index.
- req_tag  input  TAG_W  lookup tag.
- fill_en  input  1  fill (allocate) strobe.
- fill_index  input  IDX_W  fill set index.
- fill_tag  input  TAG_W  tag to install.
- resp_valid  output  1  lookup result valid; registered.
- hit_oh  output  4  one-hot hit way, bit w = way w; all-zero on miss; feeds encoder4to2 in[3:0].
- resp_hit  output  1  OR of hit_oh.
- resp_victim_oh  output  4  one-hot way a fill of the looked-up set would replace.

Behaviour:
- Storage: tag[SETS][4], valid[SETS][4], plru[SETS][3] (b0 root, b1 ways0/1, b2 ways2/3).
- Reset: clear all valid bits and PLRU bits. resp_valid, hit_oh, resp_hit and resp_victim_oh all go to 0. A rst in the same cycle as req_valid drops that response.
- Lookup latency is 1 cycle. When req_valid is high at edge N, the outputs at N+1 are:
  - resp_valid = 1.
  - hit_oh[w] = valid[idx][w] AND (tag[idx][w] == req_tag).
  - resp_victim_oh = victim(idx).
  - The compare uses the array contents before any fill written at edge N (read-before-write).
- When req_valid is low, resp_valid goes to 0 next cycle. hit_oh, resp_hit and resp_victim_oh are forced to 0 whenever resp_valid is 0.
- Victim selection, in priority order:
  - The lowest-numbered invalid way.
  - Otherwise tree PLRU: b0=0 selects the pair {0,1}, then b1=0 gives way0 and b1=1 gives way1. b0=1 selects the pair {2,3}, then b2=0 gives way2 and b2=1 gives way3.
- PLRU touch of way w sets the bits to point away from w:
  - w0: b0=1, b1=1.
  - w1: b0=1, b1=0.
  - w2: b0=0, b2=1.
  - w3: b0=0, b2=0.
- A lookup hit touches the hit way at edge N. A miss leaves the PLRU unchanged.
- Fill at edge N:
  - If fill_tag already hits a valid way in fill_index, rewrite that way.
  - Otherwise write the victim way.
  - Set valid and touch that way.
  - Duplicate tags within a set never exist, so hit_oh is always one-hot or zero.
- Fill and lookup in the same cycle:
  - Different sets: both updates apply.
  - Same set: the fill's touch wins over the lookup's touch. The lookup still sees the old contents.
- No backpressure: one request per cycle, and responses are never stalled.

Test Plan:
1. Reset, then req idx=3 tag=0x5A -> next cycle resp_valid=1, hit_oh=0000, resp_hit=0, resp_victim_oh=0001.
2. Fills to idx=3 with tags 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> ways 0, 1, 2, 3 are filled. Then req tag=0x33 -> hit_oh=0100, resp_hit=1. Then req tag=0x44 on idx=4 -> hit_oh=0000 (set isolation).
3. PLRU replacement -> continue from 2, after the lookup of 0x33:
   - Expected PLRU state: b0=0, b1=0, b2=1.
   - req tag=0x99 -> resp_victim_oh=0001.
   - fill 0x55 -> way0 is replaced.
   - req 0x11 -> miss; req 0x55 -> hit_oh=0001.
4. Same-cycle fill idx=5 tag=0x77 with req idx=5 tag=0x77 -> that response is a miss (0000). A repeat request on the next cycle -> hit_oh=0001.
5. Re-fill of existing tag 0x22 in idx=3 -> stays in way1. Lookups of 0x33 and 0x44 still hit ways 2 and 3 (0100, 1000), and no duplicate way appears.
6. rst asserted with req_valid=1 -> resp_valid=0 next cycle. After release, requests for all previously filled tags -> hit_oh=0000 and resp_victim_oh=0001.

Source files
------------

// File: rtl/cache_tag_lookup_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_tag_lookup_if
// Brief    : Lookup/fill request and registered response bundle for the
//            4-way tag store.
// Revision : 1.0
// ============================================================================
interface cache_tag_lookup_if #(
    parameter int TAG_W = 8,
    parameter int IDX_W = 3
);
    logic             req_valid;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             fill_en;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic             resp_valid;
    logic [3:0]       hit_oh;
    logic             resp_hit;
    logic [3:0]       resp_victim_oh;

    modport master (
        output req_valid, req_index, req_tag, fill_en, fill_index, fill_tag,
        input  resp_valid, hit_oh, resp_hit, resp_victim_oh
    );

    modport slave (
        input  req_valid, req_index, req_tag, fill_en, fill_index, fill_tag,
        output resp_valid, hit_oh, resp_hit, resp_victim_oh
    );
endinterface
`default_nettype wire

// File: rtl/cache_tag_lookup.sv
`default_nettype none
// ============================================================================
// Module   : cache_tag_lookup
// Brief    : 4-way set-associative tag store with tree pseudo-LRU and a
//            registered one-hot hit vector.
// Revision : 1.0
// ============================================================================
module cache_tag_lookup #(
    parameter int TAG_W = 8,
    parameter int SETS  = 8,
    parameter int IDX_W = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cache_tag_lookup_if.slave  bus
);
    localparam int c_WAYS = 4;

    logic [TAG_W-1:0] r_tag   [SETS][c_WAYS];
    logic [3:0]       r_valid [SETS];
    logic [2:0]       r_plru  [SETS];   // {b2, b1, b0}

    logic             r_resp_valid;
    logic [3:0]       r_hit_oh;
    logic [3:0]       r_victim_oh;

    logic [3:0]       w_lk_valid;
    logic [2:0]       w_lk_plru;
    logic [3:0]       w_lk_hit;
    logic [3:0]       w_lk_victim;
    logic [3:0]       w_fill_valid;
    logic [2:0]       w_fill_plru;
    logic [3:0]       w_fill_hit;
    logic [3:0]       w_fill_way;

    // Lowest invalid way first, then walk the PLRU tree.
    function automatic logic [3:0] f_victim(input logic [3:0] v, input logic [2:0] p);
        logic [3:0] r;
        if (!v[0])      r = 4'b0001;
        else if (!v[1]) r = 4'b0010;
        else if (!v[2]) r = 4'b0100;
        else if (!v[3]) r = 4'b1000;
        else if (!p[0]) r = p[1] ? 4'b0010 : 4'b0001;
        else            r = p[2] ? 4'b1000 : 4'b0100;
        return r;
    endfunction

    function automatic logic [2:0] f_touch(input logic [2:0] p, input logic [3:0] way);
        logic [2:0] r;
        r = p;
        case (way)
            4'b0001: begin r[0] = 1'b1; r[1] = 1'b1; end
            4'b0010: begin r[0] = 1'b1; r[1] = 1'b0; end
            4'b0100: begin r[0] = 1'b0; r[2] = 1'b1; end
            4'b1000: begin r[0] = 1'b0; r[2] = 1'b0; end
            default: r = p;
        endcase
        return r;
    endfunction

    always_comb begin
        w_lk_valid   = r_valid[bus.req_index];
        w_lk_plru    = r_plru[bus.req_index];
        w_fill_valid = r_valid[bus.fill_index];
        w_fill_plru  = r_plru[bus.fill_index];
        w_lk_hit     = '0;
        w_fill_hit   = '0;
        for (int w = 0; w < c_WAYS; w++) begin
            w_lk_hit[w]   = w_lk_valid[w] && (r_tag[bus.req_index][w] == bus.req_tag);
            w_fill_hit[w] = w_fill_valid[w] && (r_tag[bus.fill_index][w] == bus.fill_tag);
        end
        w_lk_victim = f_victim(w_lk_valid, w_lk_plru);
        // Re-filling a resident tag rewrites its own way so no duplicate forms.
        w_fill_way  = (|w_fill_hit) ? w_fill_hit : f_victim(w_fill_valid, w_fill_plru);
    end

    // Tag contents are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (bus.fill_en) begin
            for (int w = 0; w < c_WAYS; w++) begin
                if (w_fill_way[w]) r_tag[bus.fill_index][w] <= bus.fill_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_resp_valid <= 1'b0;
            r_hit_oh     <= '0;
            r_victim_oh  <= '0;
        end else begin
            if (bus.req_valid && (|w_lk_hit)) begin
                r_plru[bus.req_index] <= f_touch(w_lk_plru, w_lk_hit);
            end
            // Placed after the lookup touch so a same-set fill takes precedence.
            if (bus.fill_en) begin
                r_valid[bus.fill_index] <= w_fill_valid | w_fill_way;
                r_plru[bus.fill_index]  <= f_touch(w_fill_plru, w_fill_way);
            end
            r_resp_valid <= bus.req_valid;
            r_hit_oh     <= bus.req_valid ? w_lk_hit    : 4'b0000;
            r_victim_oh  <= bus.req_valid ? w_lk_victim : 4'b0000;
        end
    end

    assign bus.resp_valid     = r_resp_valid;
    assign bus.hit_oh         = r_hit_oh;
    assign bus.resp_hit       = |r_hit_oh;
    assign bus.resp_victim_oh = r_victim_oh;
endmodule
`default_nettype wire

// File: tb/tb_cache_tag_lookup.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_tag_lookup
// Brief    : Vector table plus hand sequences; expectations queued at drive
//            time and checked one cycle later.
// Revision : 1.0
// ============================================================================
module tb_cache_tag_lookup;
    typedef struct {
        logic       r;
        logic       rv;
        logic [2:0] ridx;
        logic [7:0] rtag;
        logic       fe;
        logic [2:0] fidx;
        logic [7:0] ftag;
        logic       ev;
        logic [3:0] eh;
        logic [3:0] evic;
        int         id;
    } vec_t;

    typedef struct {
        logic       v;
        logic [3:0] h;
        logic [3:0] vic;
        int         id;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   next_id;
    exp_t q[$];
    vec_t tbl[$];

    cache_tag_lookup_if #(.TAG_W(8), .IDX_W(3)) bus ();

    cache_tag_lookup #(.TAG_W(8), .SETS(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rv, input logic [2:0] ridx,
                                input logic [7:0] rtag, input logic fe, input logic [2:0] fidx,
                                input logic [7:0] ftag, input logic ev, input logic [3:0] eh,
                                input logic [3:0] evic);
        vec_t v;
        v.r = r; v.rv = rv; v.ridx = ridx; v.rtag = rtag;
        v.fe = fe; v.fidx = fidx; v.ftag = ftag;
        v.ev = ev; v.eh = eh; v.evic = evic; v.id = 0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst            = v.r;
        bus.req_valid  = v.rv;
        bus.req_index  = v.ridx;
        bus.req_tag    = v.rtag;
        bus.fill_en    = v.fe;
        bus.fill_index = v.fidx;
        bus.fill_tag   = v.ftag;
        q.push_back('{v: v.ev, h: v.eh, vic: v.evic, id: next_id});
        next_id++;
    endtask

    task automatic chk(input int id, input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %b, expected %b", id, nm, act, exp);
        end
    endtask

    // Scoreboard: each queued expectation matches the outputs after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.id, "resp_valid", {3'b0, bus.resp_valid}, {3'b0, e.v});
                chk(e.id, "hit_oh", bus.hit_oh, e.h);
                chk(e.id, "resp_hit", {3'b0, bus.resp_hit}, {3'b0, |e.h});
                chk(e.id, "resp_victim_oh", bus.resp_victim_oh, e.vic);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        next_id = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_index = '0; bus.req_tag = '0;
        bus.fill_en = 1'b0; bus.fill_index = '0; bus.fill_tag = '0;

        //                r  rv idx tag    fe fidx ftag   ev eh       evic
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 1, 3, 8'h5A, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h11, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h22, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h33, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h44, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 1, 3, 8'h33, 0, 0, 8'h00, 1, 4'b0100, 4'b0001));
        tbl.push_back(mk(0, 1, 4, 8'h44, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 1, 3, 8'h99, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h55, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 1, 3, 8'h11, 0, 0, 8'h00, 1, 4'b0000, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 8'h55, 0, 0, 8'h00, 1, 4'b0001, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h22, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 1, 3, 8'h22, 0, 0, 8'h00, 1, 4'b0010, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 8'h33, 0, 0, 8'h00, 1, 4'b0100, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 8'h44, 0, 0, 8'h00, 1, 4'b1000, 4'b0001));
        tbl.push_back(mk(0, 1, 3, 8'h55, 0, 0, 8'h00, 1, 4'b0001, 4'b0001));
        tbl.push_back(mk(0, 1, 3, 8'h11, 0, 0, 8'h00, 1, 4'b0000, 4'b0100));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Same-set fill and lookup: the lookup sees the old contents.
        apply(mk(0, 1, 5, 8'h77, 1, 5, 8'h77, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 5, 8'h77, 0, 0, 8'h00, 1, 4'b0001, 4'b0010));
        apply(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 4'b0000));

        // Different-set fill and lookup in one cycle.
        apply(mk(0, 1, 0, 8'hAA, 1, 7, 8'hAA, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 7, 8'hAA, 0, 0, 8'h00, 1, 4'b0001, 4'b0010));

        // Reset with a request pending drops the response and clears the store.
        apply(mk(1, 1, 3, 8'h33, 0, 0, 8'h00, 0, 4'b0000, 4'b0000));
        apply(mk(0, 1, 3, 8'h22, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 3, 8'h33, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 3, 8'h44, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 3, 8'h55, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 5, 8'h77, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        apply(mk(0, 1, 7, 8'hAA, 0, 0, 8'h00, 1, 4'b0000, 4'b0001));
        apply(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 4'b0000));

        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.fill_en   = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
